// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Packed table: element 0 is the rightmost entry, so F is listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: scan enable and digit data in, anode/segment drive and frame pulse out.
interface seg7_scan_driver_if;
    logic        en;
    logic [31:0] din;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    modport master (output en, din, input an, seg, frame_done);
    modport slave  (input en, din, output an, seg, frame_done);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_TABLE[hex];
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with per-digit blanking.
// A frame of digit data is latched at the start of each scan, so din may change freely mid-frame.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    seg7_scan_driver_if.slave bus
);

    localparam logic [31:0] SHOW_LAST = 32'(PRESCALE - 1);
    localparam logic [31:0] BLANK_LEN = 32'(BLANK_CYC);

    state_t      state_reg, state_next;
    logic [2:0]  digit_reg, digit_next;
    logic [31:0] cnt_reg,   cnt_next;
    logic [31:0] frame_reg, frame_next;
    logic [7:0]  an_reg,    an_next;
    logic [6:0]  seg_reg,   seg_next;
    logic        done_reg,  done_next;

    logic [3:0]  nibble [8];
    logic [7:0]  an_show;
    logic [6:0]  seg_dec;

    always_comb begin
        state_next = state_reg;
        digit_next = digit_reg;
        cnt_next   = cnt_reg + 32'd1;
        frame_next = frame_reg;
        if (!bus.en) begin
            state_next = ST_BLANK;
            digit_next = 3'd0;
            cnt_next   = 32'd0;
        end else begin
            case (state_reg)
                ST_BLANK: begin
                    // A zero-length blank still spends the single post-reset/restart cycle here.
                    if (cnt_reg + 32'd1 >= BLANK_LEN) begin
                        state_next = ST_SHOW;
                        cnt_next   = 32'd0;
                    end
                end
                ST_SHOW: begin
                    if (cnt_reg == SHOW_LAST) begin
                        digit_next = digit_reg + 3'd1;
                        cnt_next   = 32'd0;
                        state_next = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
                    end
                end
                default: begin
                    state_next = ST_BLANK;
                    cnt_next   = 32'd0;
                end
            endcase
            if (state_next == ST_SHOW && digit_next == 3'd0 && cnt_next == 32'd0) begin
                frame_next = bus.din;
            end
        end
    end

    // Outputs are decoded from next-state values so they change on the same edge as the state.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign nibble[gi]  = frame_next[4*gi +: 4];
        assign an_show[gi] = (digit_next != 3'(gi));
    end

    seg7_hex_decode u_dec (
        .hex (nibble[digit_next]),
        .seg (seg_dec)
    );

    always_comb begin
        an_next   = (state_next == ST_SHOW) ? an_show : AN_OFF;
        seg_next  = (state_next == ST_SHOW) ? seg_dec : SEG_OFF;
        done_next = bus.en && (state_next == ST_SHOW) && (digit_next == 3'd7)
                    && (cnt_next == SHOW_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_BLANK;
            digit_reg <= 3'd0;
            cnt_reg   <= 32'd0;
            frame_reg <= 32'd0;
            an_reg    <= AN_OFF;
            seg_reg   <= SEG_OFF;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            digit_reg <= digit_next;
            cnt_reg   <= cnt_next;
            frame_reg <= frame_next;
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            done_reg  <= done_next;
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.frame_done = done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: a PRESCALE=4/BLANK_CYC=1 instance and a PRESCALE=1/BLANK_CYC=0 instance.
module tb_seg7_scan_driver;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_driver_if if_a ();
    seg7_scan_driver_if if_b ();

    seg7_scan_driver #(.PRESCALE(4), .BLANK_CYC(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    seg7_scan_driver #(.PRESCALE(1), .BLANK_CYC(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cycle k of a scan for dut_a: each digit is one blank cycle then four show cycles.
    task automatic chk_scan_a(input string tag, input int k, input logic [31:0] fr);
        int ph;
        int d;
        logic [3:0] nib;
        ph  = k % 5;
        d   = (k / 5) % 8;
        nib = fr[4*d +: 4];
        chk($sformatf("%s_an_k%0d", tag, k), {24'd0, if_a.an},
            {24'd0, (ph == 0) ? 8'hFF : ~(8'd1 << d)});
        chk($sformatf("%s_seg_k%0d", tag, k), {25'd0, if_a.seg},
            {25'd0, (ph == 0) ? 7'h7F : seg_tab[nib]});
        chk($sformatf("%s_fd_k%0d", tag, k), {31'd0, if_a.frame_done},
            {31'd0, (k % 40 == 39)});
    endtask

    task automatic chk_off_a(input string tag);
        chk({tag, "_an"},  {24'd0, if_a.an},  32'hFF);
        chk({tag, "_seg"}, {25'd0, if_a.seg}, 32'h7F);
        chk({tag, "_fd"},  {31'd0, if_a.frame_done}, 32'd0);
    endtask

    always @(negedge clk) begin
        total++;
        assert (($countones(~if_a.an) <= 1) && (if_a.an != 8'hFF || if_a.seg == 7'h7F)
                && ($countones(~if_b.an) <= 1) && (if_b.an != 8'hFF || if_b.seg == 7'h7F))
        else begin
            bad++;
            $error("FAIL drive_rule observed an_a=%h seg_a=%h an_b=%h seg_b=%h required onehot-low and blank seg",
                   if_a.an, if_a.seg, if_b.an, if_b.seg);
        end
    end

    initial begin
        int d;
        logic [31:0] din_b;
        din_b = 32'hFEDCBA98;
        rst = 1'b0;
        if_a.en = 1'b1;
        if_a.din = 32'h76543210;
        if_b.en = 1'b1;
        if_b.din = din_b;
        repeat (3) step();
        chk_off_a("reset_a");
        chk("reset_b_an", {24'd0, if_b.an}, 32'hFF);

        // Run 1: basic scan, din change mid-frame; dut_b walks one digit per cycle.
        rst = 1'b1;
        for (int c = 0; c <= 50; c++) begin
            if (c > 0) step();
            if (c == 10) if_a.din = 32'hFFFFFFFF;
            chk_scan_a("run1", c, (c < 40) ? 32'h76543210 : 32'hFFFFFFFF);
            if (c == 0) begin
                chk("b_an_c0", {24'd0, if_b.an}, 32'hFF);
            end else begin
                d = (c - 1) % 8;
                chk($sformatf("b_an_c%0d", c), {24'd0, if_b.an}, {24'd0, ~(8'd1 << d)});
                chk($sformatf("b_seg_c%0d", c), {25'd0, if_b.seg}, {25'd0, seg_tab[din_b[4*d +: 4]]});
                chk($sformatf("b_fd_c%0d", c), {31'd0, if_b.frame_done}, {31'd0, d == 7});
            end
        end

        // Run 2: en low for cycles 20..22, then a fresh frame from new din.
        rst = 1'b0;
        if_a.din = 32'h76543210;
        repeat (2) step();
        rst = 1'b1;
        for (int c = 0; c <= 65; c++) begin
            if (c > 0) step();
            if (c == 20) if_a.en = 1'b0;
            if (c == 23) begin
                if_a.en = 1'b1;
                if_a.din = 32'h89ABCDEF;
            end
            if (c <= 20) chk_scan_a("run2a", c, 32'h76543210);
            else if (c <= 23) chk_off_a($sformatf("run2_enlow_c%0d", c));
            else chk_scan_a("run2b", c - 23, 32'h89ABCDEF);
        end

        // Run 3: en low in the cycle before digit 7's final show cycle suppresses frame_done.
        rst = 1'b0;
        if_a.din = 32'h76543210;
        repeat (2) step();
        rst = 1'b1;
        for (int c = 0; c <= 41; c++) begin
            if (c > 0) step();
            if (c == 38) if_a.en = 1'b0;
            if (c == 39) if_a.en = 1'b1;
            if (c <= 38) chk_scan_a("run3a", c, 32'h76543210);
            else if (c == 39) chk_off_a("run3_enlow");
            else chk_scan_a("run3b", c - 39, 32'h76543210);
        end

        // Run 4: reset during digit 5 show, then restart with reloaded frame.
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        for (int c = 0; c <= 27; c++) begin
            if (c > 0) step();
            chk_scan_a("run4a", c, 32'h76543210);
        end
        rst = 1'b0;
        if_a.din = 32'h1111111A;
        step();
        chk_off_a("run4_rst");
        rst = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) step();
            chk_scan_a("run4b", c, 32'h1111111A);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
